half_adder_sync: RTL and testbench
==================================

Name: half_adder_sync

Overview:
- Bank of WIDTH independent 1-bit half adders.
- Each lane gives combinational sum/carry: a XOR b, a AND b.
- Adds a registered copy of the results with a valid flag, plus a per-transaction carry population count.
- Used as a leaf arithmetic primitive. WIDTH=1 is the plain scalar half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (legal range 1..64).
- CNT_W, $clog2(WIDTH+1) (minimum 1), width of carry_count.

Ports:
- clk  input  1  rising-edge clock for all registers
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- a  input  WIDTH  addend A, lane i = bit i
- b  input  WIDTH  addend B, lane i = bit i
- in_valid  input  1  capture strobe for the registered path
- sum  output  WIDTH  combinational lane sums, a ^ b
- carry  output  WIDTH  combinational lane carries, a & b
- sum_q  output  WIDTH  registered sum
- carry_q  output  WIDTH  registered carry
- out_valid  output  1  registered outputs updated on the previous edge
- carry_count  output  CNT_W  registered number of set bits in carry_q

Behaviour:
- Combinational path:
  - sum[i] = a[i] XOR b[i]; carry[i] = a[i] AND b[i] for every lane.
  - Zero latency, no dependence on clk, rst_n or in_valid.
  - Valid during and after reset.
  - Lanes are fully independent; there is no carry chaining between lanes.
- Truth table per lane (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01.
- Reset: on a rising clk edge with rst_n=0, sum_q, carry_q, carry_count and out_valid are all driven to 0. Reset has priority over in_valid.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - sum_q <= a ^ b and carry_q <= a & b, from inputs sampled at that edge.
  - carry_count <= popcount(a & b).
  - out_valid <= 1.
  - Latency is 1 cycle from input to registered output.
- Hold: on a rising edge with rst_n=1 and in_valid=0, out_valid <= 0. sum_q, carry_q and carry_count hold their previous values.
- Back-to-back: in_valid held high captures every cycle and out_valid stays 1. There is no backpressure and no stall.
- Reset mid-stream: the edge with rst_n=0 clears all registers, even if in_valid=1. The first capture after release occurs on the first edge with rst_n=1 and in_valid=1.
- X/unknown inputs are not required to be filtered; outputs follow normal 4-state logic.
- carry_count maximum value is WIDTH. CNT_W always holds it without overflow.
- Registered outputs are consistent: sum_q AND carry_q is always 0 per lane.

Test Plan:
- WIDTH=1, combinational: apply a,b = 00, 01, 10, 11, one step each 5 time units apart -> sum,carry = 00, 10, 10, 01 respectively, with no clock toggling needed.
- WIDTH=1, registered: rst_n=0 for 2 edges -> sum_q=0, carry_q=0, out_valid=0, carry_count=0. Then rst_n=1, in_valid=1, a=1, b=1 -> after 1 edge carry_q=1, sum_q=0, carry_count=1, out_valid=1.
- WIDTH=8: in_valid=1, a=8'hF0, b=8'h3C -> sum=8'hCC and carry=8'h30 immediately. Next edge sum_q=8'hCC, carry_q=8'h30, carry_count=2.
- WIDTH=8 hold: capture a=b=8'hFF (carry_count=8), then in_valid=0 with new inputs a=8'h01, b=8'h00. Next edge out_valid=0, sum_q=8'h00, carry_q=8'hFF, carry_count=8 unchanged. Combinational sum=8'h01.
- Reset priority: rst_n=0 and in_valid=1 with a=b=8'hAA on the same edge -> all registered outputs 0 and out_valid=0. Combinational carry=8'hAA during reset.
- Random stream: 1000 cycles of random a, b, in_valid -> compare every edge against the reference model. Check sum_q & carry_q == 0 always.

Source files
------------

// File: rtl/half_adder_sync.sv
// Bank of WIDTH independent 1-bit half adders with a registered result stage.
//
// Ports:
//   clk         rising-edge clock for all registers
//   rst_n       synchronous active-low reset (sampled on rising clk)
//   a, b        WIDTH-bit addends, lane i = bit i
//   in_valid    capture strobe for the registered path
//   sum         combinational lane sums   (a ^ b)
//   carry       combinational lane carries (a & b)
//   sum_q       registered sum
//   carry_q     registered carry
//   out_valid   high for one cycle after each capture edge
//   carry_count registered population count of carry_q
module half_adder_sync #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic [CNT_W-1:0] w_count;

    logic [WIDTH-1:0] r_sum_q;
    logic [WIDTH-1:0] r_carry_q;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    // Lane-wise half adders; no chaining between lanes.
    assign w_sum   = a ^ b;
    assign w_carry = a & b;

    // Carry population count; CNT_W is sized to hold WIDTH.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_count = w_count + CNT_W'(w_carry[i]);
        end
    end

    // Result register: reset beats capture, data holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_q   <= '0;
            r_carry_q <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum_q   <= w_sum;
                r_carry_q <= w_carry;
                r_count   <= w_count;
            end
        end
    end

    assign sum         = w_sum;
    assign carry       = w_carry;
    assign sum_q       = r_sum_q;
    assign carry_q     = r_carry_q;
    assign carry_count = r_count;
    assign out_valid   = r_valid;

endmodule

// File: tb/tb_half_adder_sync.sv
module tb_half_adder_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       rst1_n, a1, b1, v1;
    logic       sum1, carry1, sum_q1, carry_q1, ov1;
    logic [0:0] cnt1;

    // WIDTH=8 instance
    logic       rst8_n, v8;
    logic [7:0] a8, b8, sum8, carry8, sum_q8, carry_q8;
    logic       ov8;
    logic [3:0] cnt8;

    half_adder_sync #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .in_valid(v1),
        .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
        .out_valid(ov1), .carry_count(cnt1)
    );

    half_adder_sync #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .a(a8), .b(b8), .in_valid(v8),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
        .out_valid(ov8), .carry_count(cnt8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       v;
        logic       rst_n;
        logic [7:0] e_sum;
        logic [7:0] e_carry;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [3:0] n;
        logic       v;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_sum, m_carry;
    logic [3:0] m_cnt;

    // Drive one cycle on the WIDTH=8 DUT, check comb outputs, score the registered result.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic v,
                         input logic r, input logic [7:0] e_sum, input logic [7:0] e_carry);
        exp_t e;
        a8 = a; b8 = b; v8 = v; rst8_n = r;
        #1;
        check("comb_sum8", 64'(sum8), 64'(e_sum));
        check("comb_carry8", 64'(carry8), 64'(e_carry));
        if (!r) begin
            m_sum = '0; m_carry = '0; m_cnt = '0; e.v = 1'b0;
        end else if (v) begin
            m_sum = a ^ b; m_carry = a & b; m_cnt = 4'($countones(a & b)); e.v = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.s = m_sum; e.c = m_carry; e.n = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("sum_q8", 64'(sum_q8), 64'(e.s));
            check("carry_q8", 64'(carry_q8), 64'(e.c));
            check("cnt8", 64'(cnt8), 64'(e.n));
            check("valid8", 64'(ov8), 64'(e.v));
        end
        check("excl8", 64'(sum_q8 & carry_q8), 64'd0);
    endtask

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2] = '{8'hF0, 8'h3C, 1'b1, 1'b1, 8'hCC, 8'h30};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 8'hFF};
        tbl[4] = '{8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00};
        tbl[5] = '{8'hAA, 8'hAA, 1'b1, 1'b0, 8'h00, 8'hAA};
        tbl[6] = '{8'h55, 8'h0F, 1'b1, 1'b1, 8'h5A, 8'h05};
        tbl[7] = '{8'h80, 8'h80, 1'b1, 1'b1, 8'h00, 8'h80};
        tbl[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00};

        m_sum = '0; m_carry = '0; m_cnt = '0;
        a8 = '0; b8 = '0; v8 = 1'b0; rst8_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; rst1_n = 1'b0;

        // WIDTH=1 combinational truth table
        #1;
        a1 = 0; b1 = 0; #5; check("w1_00", 64'({sum1, carry1}), 64'(2'b00));
        a1 = 0; b1 = 1; #5; check("w1_01", 64'({sum1, carry1}), 64'(2'b10));
        a1 = 1; b1 = 0; #5; check("w1_10", 64'({sum1, carry1}), 64'(2'b10));
        a1 = 1; b1 = 1; #5; check("w1_11", 64'({sum1, carry1}), 64'(2'b01));

        // WIDTH=1 registered: two reset edges, then one capture of 1+1
        rst1_n = 1'b0; v1 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("w1_rst_sum_q", 64'(sum_q1), 64'd0);
        check("w1_rst_carry_q", 64'(carry_q1), 64'd0);
        check("w1_rst_valid", 64'(ov1), 64'd0);
        check("w1_rst_cnt", 64'(cnt1), 64'd0);
        rst1_n = 1'b1; v1 = 1'b1; a1 = 1; b1 = 1;
        @(posedge clk); #1;
        check("w1_cap_carry_q", 64'(carry_q1), 64'd1);
        check("w1_cap_sum_q", 64'(sum_q1), 64'd0);
        check("w1_cap_cnt", 64'(cnt1), 64'd1);
        check("w1_cap_valid", 64'(ov1), 64'd1);
        v1 = 1'b0;
        @(posedge clk); #1;
        check("w1_hold_valid", 64'(ov1), 64'd0);
        check("w1_hold_carry_q", 64'(carry_q1), 64'd1);

        // WIDTH=8 directed table
        for (int i = 0; i < 9; i++) begin
            step8(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].rst_n, tbl[i].e_sum, tbl[i].e_carry);
        end

        // Hand-written hold sequence with fixed expectations
        step8(8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 8'hFF);
        check("hold_pre_cnt", 64'(cnt8), 64'd8);
        step8(8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00);
        check("hold_valid", 64'(ov8), 64'd0);
        check("hold_sum_q", 64'(sum_q8), 64'h00);
        check("hold_carry_q", 64'(carry_q8), 64'hFF);
        check("hold_cnt", 64'(cnt8), 64'd8);

        // Reset priority over in_valid
        step8(8'hAA, 8'hAA, 1'b1, 1'b0, 8'h00, 8'hAA);
        check("rstpri_valid", 64'(ov8), 64'd0);
        check("rstpri_carry_q", 64'(carry_q8), 64'd0);
        check("rstpri_cnt", 64'(cnt8), 64'd0);

        // Random stream with occasional resets
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rv, rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rv = ($urandom_range(3, 0) != 0);
            rr = ($urandom_range(31, 0) != 0);
            step8(ra, rb, rv, rr, ra ^ rb, ra & rb);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
